// File: rtl/pioseq_pkg.sv
// Shared definitions for the PIO pattern sequencer: FSM state encoding,
// configuration-slave register offsets and CTRL/STATUS bit positions.
package pioseq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam logic [4:0] ADDR_CTRL    = 5'd0;
    localparam logic [4:0] ADDR_PERIOD  = 5'd1;
    localparam logic [4:0] ADDR_LAST    = 5'd2;
    localparam logic [4:0] ADDR_STATUS  = 5'd3;
    localparam logic [4:0] ADDR_PATTERN = 5'd16;

    localparam int CTRL_RUN     = 0;
    localparam int CTRL_LOOP    = 1;
    localparam int CTRL_IRQ_ENA = 2;

    localparam int STATUS_BUSY     = 0;
    localparam int STATUS_DONE     = 1;
    localparam int STATUS_IRQ_PEND = 2;

endpackage

// File: rtl/pioseq_interval_timer.sv
// Interval down-counter for the WAIT state. Loaded with (spacing - 1) in the
// WRITE cycle, it decrements while enabled; expire_o flags the WAIT cycle in
// which the count reaches zero, so the next PIO write lands exactly one
// spacing after the previous one.
module pioseq_interval_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count register: load has priority, otherwise decrement while enabled
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Expire when this tick takes the count to zero
    always_comb begin
        expire_o = (cnt_q <= CNT_W'(1));
    end

endmodule

// File: rtl/pio_pattern_sequencer.sv
// Avalon-MM master that plays a CPU-loaded pattern table into an 8-bit output
// PIO, one entry every PERIOD clocks, once or looping. Configured through its
// own zero-wait-state Avalon-MM slave.
// Optional build macro PIOSEQ_IRQ_EN adds CTRL.IRQ_ENA, STATUS.IRQ_PEND and
// the irq output; without it irq is tied low and those bits read 0.
module pio_pattern_sequencer
    import pioseq_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 24,
    parameter int PIO_ADDR = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    output logic        irq
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q, state_d;
    logic              run_q, run_d;
    logic              loop_q, loop_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [3:0]        last_q, last_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] pattern_q [DEPTH];
    logic [DATA_W-1:0] pattern_d [DEPTH];
`ifdef PIOSEQ_IRQ_EN
    logic              irq_ena_q, irq_ena_d;
    logic              irq_pend_q, irq_pend_d;
`endif

    logic              wr, ctrl_wr, period_wr, last_wr, status_wr, pat_hit;
    logic [IDX_W-1:0]  last_eff;
    logic              at_last;
    logic [DATA_W-1:0] cur_entry;
    logic [CNT_W-1:0]  period_m1;
    logic              expire;
    logic              unused_wdata;

    assign unused_wdata = &{1'b0, s_writedata};

    // Slave decode, clamped last index and the table entry addressed by idx
    always_comb begin
        wr        = s_chipselect && !s_write_n;
        ctrl_wr   = wr && (s_address == ADDR_CTRL);
        period_wr = wr && (s_address == ADDR_PERIOD);
        last_wr   = wr && (s_address == ADDR_LAST);
        status_wr = wr && (s_address == ADDR_STATUS);
        pat_hit   = s_address[4] && (s_address[3:0] <= 4'(DEPTH - 1));
        last_eff  = (last_q > 4'(DEPTH - 1)) ? IDX_W'(DEPTH - 1) : last_q[IDX_W-1:0];
        at_last   = (idx_q == last_eff);
        cur_entry = pattern_q[idx_q];
        period_m1 = (period_q == '0) ? '0 : (period_q - 1'b1);
    end

    pioseq_interval_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (state_q == WRITE),
        .load_val_i (period_m1),
        .en_i       (state_q == WAIT),
        .expire_o   (expire)
    );

    // Register-file updates and sequencer next state; FSM events override
    // software clears so a DONE/IRQ_PEND set always wins over a W1C
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        loop_d    = loop_q;
        done_d    = done_q;
        period_d  = period_q;
        last_d    = last_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        pattern_d = pattern_q;
`ifdef PIOSEQ_IRQ_EN
        irq_ena_d  = irq_ena_q;
        irq_pend_d = irq_pend_q;
`endif

        if (ctrl_wr) begin
            loop_d = s_writedata[CTRL_LOOP];
`ifdef PIOSEQ_IRQ_EN
            irq_ena_d = s_writedata[CTRL_IRQ_ENA];
`endif
        end
        if (period_wr) begin
            period_d = s_writedata[CNT_W-1:0];
        end
        if (last_wr) begin
            last_d = s_writedata[3:0];
        end
        if (wr && pat_hit) begin
            pattern_d[s_address[IDX_W-1:0]] = s_writedata[DATA_W-1:0];
        end
        if (status_wr) begin
            if (s_writedata[STATUS_DONE]) begin
                done_d = 1'b0;
            end
`ifdef PIOSEQ_IRQ_EN
            if (s_writedata[STATUS_IRQ_PEND]) begin
                irq_pend_d = 1'b0;
            end
`endif
        end

        case (state_q)
            IDLE: begin
                if (ctrl_wr) begin
                    run_d = s_writedata[CTRL_RUN];
                    if (s_writedata[CTRL_RUN]) begin
                        state_d = WRITE;
                        idx_d   = '0;
                        done_d  = 1'b0;
                    end
                end
            end
            WRITE: begin
                hold_d = cur_entry;
                if (ctrl_wr && !s_writedata[CTRL_RUN]) begin
                    state_d = IDLE;
                    run_d   = 1'b0;
                end else if (at_last && !loop_q) begin
                    state_d = IDLE;
                    run_d   = 1'b0;
                    done_d  = 1'b1;
`ifdef PIOSEQ_IRQ_EN
                    irq_pend_d = 1'b1;
`endif
                end else begin
                    idx_d   = at_last ? '0 : (idx_q + 1'b1);
                    state_d = (period_m1 == '0) ? WRITE : WAIT;
`ifdef PIOSEQ_IRQ_EN
                    if (at_last) begin
                        irq_pend_d = 1'b1;
                    end
`endif
                end
            end
            WAIT: begin
                if (ctrl_wr && !s_writedata[CTRL_RUN]) begin
                    state_d = IDLE;
                    run_d   = 1'b0;
                end else if (expire) begin
                    state_d = WRITE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and register file; reset clears everything including the table
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            run_q    <= 1'b0;
            loop_q   <= 1'b0;
            done_q   <= 1'b0;
            period_q <= '0;
            last_q   <= '0;
            idx_q    <= '0;
            hold_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pattern_q[i] <= '0;
            end
`ifdef PIOSEQ_IRQ_EN
            irq_ena_q  <= 1'b0;
            irq_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            loop_q    <= loop_d;
            done_q    <= done_d;
            period_q  <= period_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            pattern_q <= pattern_d;
`ifdef PIOSEQ_IRQ_EN
            irq_ena_q  <= irq_ena_d;
            irq_pend_q <= irq_pend_d;
`endif
        end
    end

    // Slave read mux, combinational from the address
    always_comb begin
        s_readdata = '0;
        case (s_address)
            ADDR_CTRL: begin
                s_readdata[CTRL_RUN]  = run_q;
                s_readdata[CTRL_LOOP] = loop_q;
`ifdef PIOSEQ_IRQ_EN
                s_readdata[CTRL_IRQ_ENA] = irq_ena_q;
`endif
            end
            ADDR_PERIOD: s_readdata[CNT_W-1:0] = period_q;
            ADDR_LAST:   s_readdata[3:0]       = last_q;
            ADDR_STATUS: begin
                s_readdata[STATUS_BUSY] = (state_q != IDLE);
                s_readdata[STATUS_DONE] = done_q;
`ifdef PIOSEQ_IRQ_EN
                s_readdata[STATUS_IRQ_PEND] = irq_pend_q;
`endif
            end
            default: begin
                if (pat_hit) begin
                    s_readdata[DATA_W-1:0] = pattern_q[s_address[IDX_W-1:0]];
                end
            end
        endcase
    end

    // Master port: one-cycle write strobe in WRITE, data held between writes;
    // the strobe is gated by reset so an abort drops it in the same cycle
    always_comb begin
        m_address    = 2'(PIO_ADDR);
        m_chipselect = (state_q == WRITE) && reset_n;
        m_write_n    = !m_chipselect;
        m_writedata  = {{(32 - DATA_W){1'b0}}, ((state_q == WRITE) ? cur_entry : hold_q)};
`ifdef PIOSEQ_IRQ_EN
        irq = irq_pend_q && irq_ena_q;
`else
        irq = 1'b0;
`endif
    end

endmodule

// File: tb/tb_pio_pattern_sequencer.sv
// Directed bench for pio_pattern_sequencer: a register-access vector table
// followed by hand-written multi-cycle sequences on the PIO master port.
module tb_pio_pattern_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  s_address = '0;
    logic        s_chipselect = 1'b0;
    logic        s_write_n = 1'b1;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        irq;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_cyc = 0;
    logic [31:0] wd_q[$];
    int          wc_q[$];

    pio_pattern_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_write_n    (s_write_n),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every PIO write strobe with its cycle number
    always @(negedge clk) begin
        if (m_chipselect && !m_write_n) begin
            wd_q.push_back(m_writedata);
            wc_q.push_back(cyc);
        end
    end

    typedef struct {
        bit          do_wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic slv_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        s_address    = a;
        s_writedata  = d;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        wr_cyc       = cyc;
        @(negedge clk);
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic slv_rd(input logic [4:0] a, output logic [31:0] d);
        s_address = a;
        #1;
        d = s_readdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic clear_log();
        wd_q.delete();
        wc_q.delete();
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int k = 0;
        while (wd_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk(name, 32'(wd_q.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        logic [31:0] st;
        slv_rd(5'd3, st);
        while (!st[1] && k < budget) begin
            @(posedge clk);
            #1;
            st = s_readdata;
            k++;
        end
        chk(name, 32'(st[1]), 32'd1);
    endtask

    initial begin
        vec_t        vecs[10];
        logic [31:0] rd;
        int          bad;
        logic [31:0] ctrl_exp;

`ifdef PIOSEQ_IRQ_EN
        ctrl_exp = 32'h6;
`else
        ctrl_exp = 32'h2;
`endif
        vecs[0] = '{1'b1, 5'd1,  32'hFFFF_FFFF, 32'h00FF_FFFF};
        vecs[1] = '{1'b1, 5'd2,  32'hFFFF_FFFF, 32'h0000_000F};
        vecs[2] = '{1'b1, 5'd16, 32'h0000_01AB, 32'h0000_00AB};
        vecs[3] = '{1'b1, 5'd23, 32'h0000_00C3, 32'h0000_00C3};
        vecs[4] = '{1'b1, 5'd24, 32'h0000_0077, 32'h0000_0000};
        vecs[5] = '{1'b0, 5'd4,  32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{1'b1, 5'd0,  32'h0000_0006, ctrl_exp};
        vecs[7] = '{1'b0, 5'd3,  32'h0000_0000, 32'h0000_0000};
        vecs[8] = '{1'b1, 5'd3,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[9] = '{1'b1, 5'd0,  32'h0000_0000, 32'h0000_0000};

        // Reset state
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_m_chipselect", 32'(m_chipselect), 32'd0);
        chk("rst_m_write_n", 32'(m_write_n), 32'd1);
        chk("rst_m_writedata", m_writedata, 32'd0);
        chk("rst_m_address", 32'(m_address), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        for (int a = 0; a < 4; a++) begin
            slv_rd(5'(a), rd);
            chk($sformatf("rst_reg%0d", a), rd, 32'd0);
        end

        // Register access table
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_wr) slv_wr(vecs[i].addr, vecs[i].wdata);
            slv_rd(vecs[i].addr, rd);
            chk($sformatf("vec%0d_addr%0d", i, vecs[i].addr), rd, vecs[i].exp);
        end
        do_reset();

        // One-shot 01,02,04,08 every 5 clocks
        slv_wr(5'd16, 32'h01);
        slv_wr(5'd17, 32'h02);
        slv_wr(5'd18, 32'h04);
        slv_wr(5'd19, 32'h08);
        slv_wr(5'd2, 32'd3);
        slv_wr(5'd1, 32'd5);
        clear_log();
        slv_wr(5'd0, 32'h1);
        wait_done(100, "oneshot_done");
        chk("oneshot_count", 32'(wd_q.size()), 32'd4);
        if (wd_q.size() == 4) begin
            chk("oneshot_latency", 32'(wc_q[0]), 32'(wr_cyc + 1));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("oneshot_data%0d", i), wd_q[i], 32'(1 << i));
                if (i > 0) chk($sformatf("oneshot_gap%0d", i), 32'(wc_q[i] - wc_q[i-1]), 32'd5);
            end
        end
        slv_rd(5'd3, rd);
        chk("oneshot_status", rd, 32'h2);
        slv_rd(5'd0, rd);
        chk("oneshot_ctrl_run_clr", rd, 32'h0);
        @(negedge clk);
        chk("hold_writedata", m_writedata, 32'h08);

        // Loop AA,55 back-to-back, then stop
        do_reset();
        clear_log();
        slv_wr(5'd16, 32'hAA);
        slv_wr(5'd17, 32'h55);
        slv_wr(5'd2, 32'd1);
        slv_wr(5'd0, 32'h3);
        wait_writes(6, 50, "loop_progress");
        slv_rd(5'd3, rd);
        chk("loop_busy", rd, 32'h1);
        bad = 0;
        for (int i = 0; i < 6 && i < wd_q.size(); i++) begin
            if (wd_q[i] !== ((i % 2 == 0) ? 32'hAA : 32'h55)) bad++;
            if (i > 0 && (wc_q[i] - wc_q[i-1]) != 1) bad++;
        end
        chk("loop_alternate_bad", 32'(bad), 32'd0);
        slv_wr(5'd0, 32'h0);
        repeat (3) @(negedge clk);
        slv_rd(5'd3, rd);
        chk("loop_stopped_status", rd, 32'h0);

        // LAST=0 loop, stop in the middle of WAIT
        do_reset();
        clear_log();
        slv_wr(5'd16, 32'h11);
        slv_wr(5'd1, 32'd6);
        slv_wr(5'd0, 32'h3);
        wait_writes(2, 50, "stop_progress");
        slv_wr(5'd0, 32'h2);
        repeat (20) @(negedge clk);
        chk("stop_count", 32'(wd_q.size()), 32'd2);
        if (wd_q.size() >= 2) begin
            chk("stop_same_entry", wd_q[1], 32'h11);
            chk("stop_gap", 32'(wc_q[1] - wc_q[0]), 32'd6);
        end
        slv_rd(5'd3, rd);
        chk("stop_status", rd, 32'h0);
        slv_rd(5'd0, rd);
        chk("stop_ctrl", rd, 32'h2);

        // PERIOD rewritten during WAIT only affects later gaps
        do_reset();
        clear_log();
        slv_wr(5'd16, 32'h01);
        slv_wr(5'd17, 32'h02);
        slv_wr(5'd18, 32'h04);
        slv_wr(5'd19, 32'h08);
        slv_wr(5'd2, 32'd3);
        slv_wr(5'd1, 32'd3);
        slv_wr(5'd0, 32'h1);
        wait_writes(1, 20, "period_first");
        slv_wr(5'd1, 32'd10);
        wait_done(100, "period_done");
        chk("period_count", 32'(wd_q.size()), 32'd4);
        if (wd_q.size() == 4) begin
            chk("period_gap1", 32'(wc_q[1] - wc_q[0]), 32'd3);
            chk("period_gap2", 32'(wc_q[2] - wc_q[1]), 32'd10);
            chk("period_gap3", 32'(wc_q[3] - wc_q[2]), 32'd10);
        end
        slv_wr(5'd3, 32'h2);
        slv_rd(5'd3, rd);
        chk("done_w1c", rd, 32'h0);

        // LAST beyond the table clamps to the final entry
        do_reset();
        clear_log();
        for (int i = 0; i < 8; i++) slv_wr(5'(16 + i), 32'(8'h10 + i));
        slv_wr(5'd2, 32'd15);
        slv_wr(5'd0, 32'h1);
        wait_done(100, "clamp_done");
        chk("clamp_count", 32'(wd_q.size()), 32'd8);
        if (wd_q.size() == 8) begin
            chk("clamp_last_data", wd_q[7], 32'h17);
            chk("clamp_span", 32'(wc_q[7] - wc_q[0]), 32'd7);
        end

        // Reset pulse in the middle of WAIT aborts the sequence
        do_reset();
        clear_log();
        slv_wr(5'd16, 32'h5A);
        slv_wr(5'd1, 32'd8);
        slv_wr(5'd0, 32'h3);
        wait_writes(1, 20, "rstmid_first");
        do_reset();
        chk("rstmid_write_n", 32'(m_write_n), 32'd1);
        chk("rstmid_chipselect", 32'(m_chipselect), 32'd0);
        slv_rd(5'd3, rd);
        chk("rstmid_status", rd, 32'h0);
        slv_rd(5'd0, rd);
        chk("rstmid_ctrl", rd, 32'h0);
        repeat (20) @(negedge clk);
        chk("rstmid_count", 32'(wd_q.size()), 32'd1);

        // Completion interrupt on a one-shot single-entry run
        do_reset();
        clear_log();
        slv_wr(5'd16, 32'h3C);
`ifdef PIOSEQ_IRQ_EN
        slv_wr(5'd0, 32'h5);
`else
        slv_wr(5'd0, 32'h1);
`endif
        wait_writes(1, 20, "irq_write");
        #1;
        slv_rd(5'd3, rd);
`ifdef PIOSEQ_IRQ_EN
        chk("irq_set", 32'(irq), 32'd1);
        chk("irq_status", rd, 32'h6);
        slv_wr(5'd3, 32'h4);
        chk("irq_cleared", 32'(irq), 32'd0);
        slv_rd(5'd3, rd);
        chk("irq_status_after_w1c", rd, 32'h2);
`else
        chk("irq_tied_low", 32'(irq), 32'd0);
        chk("irq_status", rd, 32'h2);
`endif
        if (wd_q.size() >= 1) chk("irq_data", wd_q[0], 32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
